// File: rtl/fp_pkg.sv
// Shared types and widths for the FP add/sub normalization datapath.
package fp_pkg;

  localparam int unsigned MANT_W  = 28;
  localparam int unsigned EXP_W   = 8;
  localparam int unsigned LZ_W    = $clog2(MANT_W) + 1;
  localparam int unsigned EXPX_W  = EXP_W + 1;
  localparam int unsigned EXP_MAX = 255;

  typedef enum logic [1:0] {
    ZERO,
    RIGHT1,
    LEFT
  } shift_cls_e;

  // Stage-1 payload: decoded shift class plus the already-adjusted exponent.
  typedef struct packed {
    logic              sign;
    shift_cls_e        cls;
    logic [LZ_W-1:0]   sh;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
    logic              ovf;
    logic              unf;
    logic              flush;
  } s1_payload_t;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-2:0] mant;
    logic              ovf;
    logic              unf;
  } norm_out_t;

endpackage

// File: rtl/fp_lshift_sticky.sv
// Logarithmic barrel shifter: left shift, or right shift with the shifted-out
// bits ORed into the LSB so the sticky information survives.
module fp_lshift_sticky #(
  parameter int unsigned W     = 28,
  parameter int unsigned SH_W  = 5,
  parameter int unsigned OUT_W = 27
) (
  input  logic [W-1:0]     i_data,
  input  logic [SH_W-1:0]  i_shamt,
  input  logic             i_right,
  output logic [OUT_W-1:0] o_data
);

  logic [W-1:0] x;
  logic [W-1:0] mask;
  logic         lost;

  always_comb begin
    x    = i_data;
    mask = '0;
    lost = 1'b0;
    for (int k = 0; k < int'(SH_W); k++) begin
      if (i_shamt[k]) begin
        if (i_right) begin
          mask = (W'(1) << (1 << k)) - W'(1);
          lost = |(x & mask);
          x    = (x >> (1 << k)) | W'(lost);
        end else begin
          x = x << (1 << k);
        end
      end
    end
    o_data = x[OUT_W-1:0];
  end

endmodule

// File: rtl/fp_norm_shift.sv
// Two-stage elastic normalization stage of the FP add/sub datapath.
// Define FP_NORM_DENORM_EN for gradual underflow; otherwise underflow flushes to zero.
module fp_norm_shift
  import fp_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic              i_sign,
  input  logic [EXP_W-1:0]  i_exp,
  input  logic [MANT_W-1:0] i_mant,
  input  logic [LZ_W-1:0]   i_lz_cnt,
  input  logic              i_zero,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_sign,
  output logic [EXP_W-1:0]  o_exp,
  output logic [MANT_W-2:0] o_mant,
  output logic              o_overflow,
  output logic              o_underflow
);

  logic        valid1_q, valid1_d;
  logic        valid2_q, valid2_d;
  s1_payload_t s1_q, s1_d;
  norm_out_t   out_q, out_d;

  logic              stage_en1, stage_en2;
  logic [EXPX_W-1:0] exp_ext, exp_inc, sh_ext;
  logic [LZ_W-1:0]   sh_amt;
  logic              is_right;
  logic [MANT_W-2:0] shifted;

  assign stage_en2 = ~valid2_q | i_ready;
  assign stage_en1 = ~valid1_q | stage_en2;
  assign o_ready   = stage_en1;

  // Stage 1: classify the shift and settle the exponent at EXP_W+1 bits.
  always_comb begin
    exp_ext  = {1'b0, i_exp};
    exp_inc  = exp_ext + EXPX_W'(1);
    sh_ext   = (i_lz_cnt == '0) ? '0 : EXPX_W'(i_lz_cnt) - EXPX_W'(1);
    valid1_d = valid1_q;
    s1_d     = s1_q;
    if (stage_en1) begin
      valid1_d = i_valid;
      if (i_valid) begin
        s1_d      = '0;
        s1_d.sign = i_sign;
        s1_d.mant = i_mant;
        s1_d.cls  = LEFT;
        if (i_exp == EXP_W'(EXP_MAX)) begin
          s1_d.exp = i_exp;
          s1_d.ovf = 1'b1;
        end else if (i_zero) begin
          s1_d.cls = ZERO;
        end else if (i_mant[MANT_W-1]) begin
          s1_d.cls = RIGHT1;
          if (exp_inc >= EXPX_W'(EXP_MAX)) begin
            s1_d.exp   = EXP_W'(EXP_MAX);
            s1_d.ovf   = 1'b1;
            s1_d.flush = 1'b1;
          end else begin
            s1_d.exp = exp_inc[EXP_W-1:0];
          end
        end else if (exp_ext > sh_ext) begin
          s1_d.sh  = sh_ext[LZ_W-1:0];
          s1_d.exp = EXP_W'(exp_ext - sh_ext);
        end else begin
          s1_d.unf = 1'b1;
`ifdef FP_NORM_DENORM_EN
          s1_d.sh  = (i_exp == '0) ? '0 : LZ_W'(i_exp - EXP_W'(1));
`else
          s1_d.flush = 1'b1;
`endif
        end
      end
    end
  end

  assign is_right = (s1_q.cls == RIGHT1);
  assign sh_amt   = is_right ? LZ_W'(1) : s1_q.sh;

  fp_lshift_sticky #(
    .W     (MANT_W),
    .SH_W  (LZ_W),
    .OUT_W (MANT_W - 1)
  ) u_shift (
    .i_data  (s1_q.mant),
    .i_shamt (sh_amt),
    .i_right (is_right),
    .o_data  (shifted)
  );

  // Stage 2: register the shifted mantissa and flags.
  always_comb begin
    valid2_d = valid2_q;
    out_d    = out_q;
    if (stage_en2) begin
      valid2_d = valid1_q;
      if (valid1_q) begin
        out_d.sign = s1_q.sign;
        out_d.exp  = s1_q.exp;
        out_d.ovf  = s1_q.ovf;
        out_d.unf  = s1_q.unf;
        out_d.mant = ((s1_q.cls == ZERO) || s1_q.flush) ? '0 : shifted;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid1_q <= 1'b0;
      valid2_q <= 1'b0;
      s1_q     <= '0;
      out_q    <= '0;
    end else begin
      valid1_q <= valid1_d;
      valid2_q <= valid2_d;
      s1_q     <= s1_d;
      out_q    <= out_d;
    end
  end

  assign o_valid     = valid2_q;
  assign o_sign      = out_q.sign;
  assign o_exp       = out_q.exp;
  assign o_mant      = out_q.mant;
  assign o_overflow  = out_q.ovf;
  assign o_underflow = out_q.unf;

endmodule

// File: tb/tb_fp_norm_shift.sv
// Bench for fp_norm_shift: directed vectors, backpressure stream, random traffic, mid-stream reset.
`timescale 1ns/1ps
module tb_fp_norm_shift;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_valid;
  logic        o_ready;
  logic        i_sign;
  logic [7:0]  i_exp;
  logic [27:0] i_mant;
  logic [4:0]  i_lz_cnt;
  logic        i_zero;
  logic        o_valid;
  logic        i_ready;
  logic        o_sign;
  logic [7:0]  o_exp;
  logic [26:0] o_mant;
  logic        o_overflow;
  logic        o_underflow;

  fp_norm_shift dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_sign      (i_sign),
    .i_exp       (i_exp),
    .i_mant      (i_mant),
    .i_lz_cnt    (i_lz_cnt),
    .i_zero      (i_zero),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_sign      (o_sign),
    .o_exp       (o_exp),
    .o_mant      (o_mant),
    .o_overflow  (o_overflow),
    .o_underflow (o_underflow)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        sign;
    logic [7:0]  exp;
    logic [27:0] mant;
    logic [4:0]  lz;
    logic        zero;
  } stim_t;

  typedef struct {
    logic        sign;
    logic [7:0]  exp;
    logic [26:0] mant;
    logic        ovf;
    logic        unf;
  } res_t;

  int          n_total = 0;
  int          n_bad   = 0;
  int          n_emit  = 0;
  res_t        sb[$];
  stim_t       pend[$];
  stim_t       cur;
  bit          cur_valid = 1'b0;
  bit          prev_stall = 1'b0;
  logic [63:0] prev_out = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, want);
    end
  endtask

  function automatic logic [63:0] pack_out();
    return 64'({o_sign, o_exp, o_mant, o_overflow, o_underflow});
  endfunction

  function automatic logic [63:0] pack_res(input res_t r);
    return 64'({r.sign, r.exp, r.mant, r.ovf, r.unf});
  endfunction

  function automatic res_t mk(input logic s, input logic [7:0] e, input logic [26:0] m,
                              input logic ov, input logic un);
    res_t r;
    r.sign = s; r.exp = e; r.mant = m; r.ovf = ov; r.unf = un;
    return r;
  endfunction

  function automatic stim_t mks(input logic s, input logic [7:0] e, input logic [27:0] m,
                                input logic [4:0] lz, input logic z);
    stim_t t;
    t.sign = s; t.exp = e; t.mant = m; t.lz = lz; t.zero = z;
    return t;
  endfunction

  // Reference: normalization rules evaluated with plain integer arithmetic.
  function automatic res_t model(input stim_t s);
    res_t   r;
    longint m;
    int     e;
    int     sh;
    r = mk(s.sign, 8'd0, 27'd0, 1'b0, 1'b0);
    m = longint'(s.mant);
    e = int'(s.exp);
    if (e == 255) begin
      r.exp  = 8'd255;
      r.mant = s.mant[26:0];
      r.ovf  = 1'b1;
    end else if (s.zero) begin
      r.exp = 8'd0;
    end else if (m >= 64'h8000000) begin
      if (e + 1 >= 255) begin
        r.exp = 8'd255;
        r.ovf = 1'b1;
      end else begin
        r.exp  = 8'(e + 1);
        r.mant = 27'((m >> 1) | (m & 64'd1));
      end
    end else begin
      sh = int'(s.lz) - 1;
      if (e > sh) begin
        r.exp  = 8'(e - sh);
        r.mant = 27'(m << sh);
      end else begin
        r.unf = 1'b1;
`ifdef FP_NORM_DENORM_EN
        r.mant = 27'(m << (e - 1));
`endif
      end
    end
    return r;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    int    k;
    int    lz;
    s.sign = 1'($urandom_range(0, 1));
    s.zero = 1'b0;
    s.lz   = 5'd0;
    s.exp  = 8'($urandom_range(1, 254));
    k = $urandom_range(0, 11);
    if (k == 0) begin
      s.zero = 1'b1;
      s.mant = 28'd0;
      s.lz   = 5'($urandom_range(0, 27));
    end else if (k <= 3) begin
      s.mant = {1'b1, 27'($urandom())};
      if (k == 3) s.exp = 8'($urandom_range(250, 254));
    end else if (k == 11) begin
      s.exp  = 8'd255;
      s.mant = 28'($urandom());
      s.lz   = 5'($urandom_range(0, 27));
    end else begin
      lz     = $urandom_range(1, 27);
      s.lz   = 5'(lz);
      s.mant = 28'((32'd1 << (27 - lz)) | ($urandom() & ((32'd1 << (27 - lz)) - 32'd1)));
      if (k >= 9) s.exp = 8'($urandom_range(1, 30));
    end
    return s;
  endfunction

  task automatic drive(input stim_t s, input bit v);
    i_valid  = v;
    i_sign   = s.sign;
    i_exp    = s.exp;
    i_mant   = s.mant;
    i_lz_cnt = s.lz;
    i_zero   = s.zero;
  endtask

  // Single transfer into an empty pipe with the sink ready: checks latency and data.
  task automatic run_one(input string tag, input stim_t s, input res_t want);
    i_ready = 1'b1;
    drive(s, 1'b1);
    @(negedge i_clk);
    i_valid = 1'b0;
    chk({tag, "_lat1"}, 64'(o_valid), 64'd0);
    @(negedge i_clk);
    chk({tag, "_vld"}, 64'(o_valid), 64'd1);
    chk(tag, pack_out(), pack_res(want));
    @(negedge i_clk);
  endtask

  // One clock of the streaming engine, entered and left at a falling edge.
  task automatic step(input bit wv, input bit rd);
    logic [63:0] cur_out;
    logic        exp_rdy;
    bit          emit;
    bit          acc;
    res_t        r;
    if (!cur_valid && wv && pend.size() > 0) begin
      cur       = pend.pop_front();
      cur_valid = 1'b1;
    end
    drive(cur, cur_valid);
    i_ready = rd;
    #1;
    exp_rdy = (sb.size() < 2) ? 1'b1 : rd;
    chk("o_ready", 64'(o_ready), 64'(exp_rdy));
    cur_out = pack_out();
    if (prev_stall) chk("stall_hold", cur_out, prev_out);
    if (sb.size() == 0) chk("idle_valid", 64'(o_valid), 64'd0);
    emit = o_valid & i_ready;
    acc  = i_valid & o_ready;
    if (emit && sb.size() > 0) begin
      r = sb.pop_front();
      chk("data", cur_out, pack_res(r));
      n_emit++;
    end
    if (acc) begin
      sb.push_back(model(cur));
      cur_valid = 1'b0;
    end
    prev_stall = o_valid & ~i_ready;
    prev_out   = cur_out;
    @(negedge i_clk);
  endtask

  task automatic run_phase(input string tag, input int n, input bit rnd, input int budget);
    int c;
    bit wv;
    bit rd;
    c          = 0;
    n_emit     = 0;
    prev_stall = 1'b0;
    for (int i = 0; i < n; i++) pend.push_back(rand_stim());
    while ((pend.size() > 0 || cur_valid || sb.size() > 0) && c < budget) begin
      if (rnd) begin
        wv = ($urandom_range(0, 3) != 0);
        rd = ($urandom_range(0, 9) < 7);
      end else begin
        wv = 1'b1;
        rd = !(c >= 4 && c <= 6);
      end
      step(wv, rd);
      c++;
    end
    chk({tag, "_drain"}, 64'(c < budget), 64'd1);
    chk({tag, "_count"}, 64'(n_emit), 64'(n));
  endtask

  initial begin
    i_rst_n = 1'b1;
    i_ready = 1'b1;
    drive(mks(1'b0, 8'd0, 28'd0, 5'd0, 1'b0), 1'b0);
    #2 i_rst_n = 1'b0;
    @(negedge i_clk);
    @(negedge i_clk);
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_ready", 64'(o_ready), 64'd1);
    chk("rst_outs", pack_out(), 64'd0);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    run_one("norm",    mks(1'b0, 8'd127, 28'h4000000, 5'd1, 1'b0),  mk(1'b0, 8'd127, 27'h4000000, 1'b0, 1'b0));
    run_one("right1",  mks(1'b0, 8'd130, 28'h8000003, 5'd0, 1'b0),  mk(1'b0, 8'd131, 27'h4000001, 1'b0, 1'b0));
    run_one("r1_edge", mks(1'b1, 8'd253, 28'h8000003, 5'd0, 1'b0),  mk(1'b1, 8'd254, 27'h4000001, 1'b0, 1'b0));
    run_one("ovf",     mks(1'b0, 8'd254, 28'h8000003, 5'd0, 1'b0),  mk(1'b0, 8'd255, 27'h0000000, 1'b1, 1'b0));
    run_one("inf_in",  mks(1'b1, 8'd255, 28'h1234567, 5'd3, 1'b0),  mk(1'b1, 8'd255, 27'h1234567, 1'b1, 1'b0));
    run_one("left18",  mks(1'b0, 8'd100, 28'h0000100, 5'd19, 1'b0), mk(1'b0, 8'd82,  27'h4000000, 1'b0, 1'b0));
    run_one("left_min", mks(1'b0, 8'd19, 28'h0000100, 5'd19, 1'b0), mk(1'b0, 8'd1,   27'h4000000, 1'b0, 1'b0));
    run_one("zero",    mks(1'b1, 8'd77,  28'h0000000, 5'd9, 1'b1),  mk(1'b1, 8'd0,   27'h0000000, 1'b0, 1'b0));
`ifdef FP_NORM_DENORM_EN
    run_one("unf10",   mks(1'b0, 8'd10, 28'h0000100, 5'd19, 1'b0),  mk(1'b0, 8'd0, 27'h0020000, 1'b0, 1'b1));
    run_one("unf18",   mks(1'b1, 8'd18, 28'h0000100, 5'd19, 1'b0),  mk(1'b1, 8'd0, 27'h2000000, 1'b0, 1'b1));
`else
    run_one("unf10",   mks(1'b0, 8'd10, 28'h0000100, 5'd19, 1'b0),  mk(1'b0, 8'd0, 27'h0000000, 1'b0, 1'b1));
    run_one("unf18",   mks(1'b1, 8'd18, 28'h0000100, 5'd19, 1'b0),  mk(1'b1, 8'd0, 27'h0000000, 1'b0, 1'b1));
`endif

    run_phase("stream", 8, 1'b0, 60);
    run_phase("random", 300, 1'b1, 3000);

    prev_stall = 1'b0;
    for (int i = 0; i < 6; i++) pend.push_back(rand_stim());
    for (int c = 0; c < 4; c++) step(1'b1, 1'b1);
    chk("pre_rst_valid", 64'(o_valid), 64'd1);
    #2 i_rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(o_valid), 64'd0);
    chk("mid_rst_ready", 64'(o_ready), 64'd1);
    sb.delete();
    pend.delete();
    cur_valid = 1'b0;
    i_valid   = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    @(negedge i_clk);
    chk("post_rst_valid", 64'(o_valid), 64'd0);

    run_phase("recover", 40, 1'b1, 500);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
